// File: rtl/clean_request_ctrl.sv
// clean_request_ctrl: upstream controller for the hood self-clean stage.
// Debounces the front-panel clean button, accumulates fan-extraction seconds
// into a usage counter with a reminder flag, issues a one-cycle start_clean
// request and tracks the self-clean stage's cleaning/done handshake.
//
// Optional build macro: AUTO_CLEAN_EN -- when defined, an IDLE controller also
// requests a clean by itself once clean_reminder, power_on and in_standby have
// held together across one full tick_1s period.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tick_1s         one-cycle 1 Hz enable
//   power_on        hood powered
//   in_standby      hood in standby (fan off, no other mode)
//   extracting      fan running at any speed
//   btn_clean       raw asynchronous clean button, active-high
//   cleaning        busy level from the self-clean stage
//   done            completion level/pulse from the self-clean stage
//   start_clean     one-cycle request to the self-clean stage
//   clean_reminder  usage_sec >= REMIND_SECS
//   usage_sec       accumulated extraction seconds (saturating)
//   req_reject      one-cycle pulse: button press refused
//   ack_error       sticky: self-clean stage did not acknowledge in time
module clean_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned REMIND_SECS     = 36000,
    parameter int unsigned USAGE_W         = 17,
    parameter int unsigned ACK_TIMEOUT     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1s,
    input  logic               power_on,
    input  logic               in_standby,
    input  logic               extracting,
    input  logic               btn_clean,
    input  logic               cleaning,
    input  logic               done,
    output logic               start_clean,
    output logic               clean_reminder,
    output logic [USAGE_W-1:0] usage_sec,
    output logic               req_reject,
    output logic               ack_error
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_ACK = 2'd2,
        RUNNING  = 2'd3
    } state_t;

    state_t state, next_state;

    // Two-flop synchronizer for the asynchronous button
    logic btn_meta, btn_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_clean;
            btn_sync <= btn_meta;
        end
    end

    // Debouncer: the level flips on the Nth consecutive cycle that differs from it
    logic            btn_level;
    logic [DB_W-1:0] db_cnt;
    logic            db_flip_c;
    logic            press_c;

    assign db_flip_c = (btn_sync != btn_level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press_c   = db_flip_c && btn_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= 1'b0;
            db_cnt    <= '0;
        end else if (btn_sync == btn_level) begin
            db_cnt <= '0;
        end else if (db_flip_c) begin
            btn_level <= btn_sync;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Rising-edge detect on done
    logic done_q;
    logic done_rise_c;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done;
    end
    assign done_rise_c = done && !done_q;

`ifdef AUTO_CLEAN_EN
    // Arms on a tick with the condition true; fires on the next tick if still true
    logic auto_cond_c;
    logic auto_armed;
    logic auto_req_c;

    assign auto_cond_c = clean_reminder && power_on && in_standby;
    assign auto_req_c  = auto_cond_c && auto_armed && tick_1s && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  auto_armed <= 1'b0;
        else if (!auto_cond_c || state != IDLE)   auto_armed <= 1'b0;
        else if (tick_1s)                         auto_armed <= 1'b1;
    end
`else
    logic auto_req_c;
    assign auto_req_c = 1'b0;
`endif

    logic [ACK_W-1:0] ack_cnt;
    logic             clear_c;
    logic             ack_timeout_c;

    // Next-state logic; power loss outside IDLE always abandons the request
    always_comb begin
        next_state    = state;
        clear_c       = 1'b0;
        ack_timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (press_c && power_on && in_standby) next_state = REQUEST;
                else if (auto_req_c)                   next_state = REQUEST;
            end
            REQUEST: begin
                next_state = power_on ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                if (!power_on) begin
                    next_state = IDLE;
                end else if (cleaning) begin
                    next_state = RUNNING;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    next_state    = IDLE;
                    ack_timeout_c = 1'b1;
                end
            end
            RUNNING: begin
                if (!power_on) begin
                    next_state = IDLE;
                end else if (done_rise_c) begin
                    next_state = IDLE;
                    clear_c    = 1'b1;
                end else if (!cleaning) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    logic               start_d;
    logic               reject_d;
    logic               ack_err_d;
    logic [ACK_W-1:0]   ack_cnt_d;
    logic [USAGE_W-1:0] usage_d;
    logic               reminder_d;

    // Next values of the registered outputs; a completed clean beats a coincident tick
    always_comb begin
        start_d    = 1'b0;
        reject_d   = 1'b0;
        ack_err_d  = ack_error;
        ack_cnt_d  = ack_cnt;
        usage_d    = usage_sec;
        reminder_d = clean_reminder;

        start_d  = (state == IDLE) && (next_state == REQUEST);
        reject_d = (state == IDLE) && press_c && !(power_on && in_standby);

        if (ack_timeout_c) ack_err_d = 1'b1;

        if (state == REQUEST)       ack_cnt_d = '0;
        else if (state == WAIT_ACK) ack_cnt_d = ack_cnt + ACK_W'(1);

        if (clear_c) begin
            usage_d = '0;
        end else if (tick_1s && power_on && extracting && !cleaning && (usage_sec != '1)) begin
            usage_d = usage_sec + USAGE_W'(1);
        end
        reminder_d = (usage_d >= USAGE_W'(REMIND_SECS));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ack_cnt        <= '0;
            start_clean    <= 1'b0;
            req_reject     <= 1'b0;
            ack_error      <= 1'b0;
            usage_sec      <= '0;
            clean_reminder <= 1'b0;
        end else begin
            state          <= next_state;
            ack_cnt        <= ack_cnt_d;
            start_clean    <= start_d;
            req_reject     <= reject_d;
            ack_error      <= ack_err_d;
            usage_sec      <= usage_d;
            clean_reminder <= reminder_d;
        end
    end

endmodule

// File: tb/tb_clean_request_ctrl.sv
// Testbench for clean_request_ctrl: directed scenarios with randomized
// glitch lengths, tick gaps and input noise, checked against a usage model
// and a cycle-level self-clean stage model kept in the bench.
module tb_clean_request_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned REM  = 10;
    localparam int unsigned ACKT = 4;
    localparam int unsigned UW   = 17;
    localparam int          LAT  = DB + 2;   // button edge to start_clean/req_reject

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_1s, power_on, in_standby, extracting, btn_clean, cleaning, done;
    logic          start_clean, clean_reminder, req_reject, ack_error;
    logic [UW-1:0] usage_sec;

    always #5 clk = ~clk;

    clean_request_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REMIND_SECS     (REM),
        .USAGE_W         (UW),
        .ACK_TIMEOUT     (ACKT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_1s        (tick_1s),
        .power_on       (power_on),
        .in_standby     (in_standby),
        .extracting     (extracting),
        .btn_clean      (btn_clean),
        .cleaning       (cleaning),
        .done           (done),
        .start_clean    (start_clean),
        .clean_reminder (clean_reminder),
        .usage_sec      (usage_sec),
        .req_reject     (req_reject),
        .ack_error      (ack_error)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference usage: qualifying seconds since the last completed clean
    int ref_usage   = 0;
    bit clean_armed = 0;

    // Self-clean stage model: 0 normal, 1 never acknowledges, 2 holds cleaning
    int sc_t    = -1;
    int sc_mode = 0;

    int n_start, n_rej, first_start, first_rej, first_ackerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: reference update for the coming edge, then self-clean model at negedge
    task automatic step(input bit t);
        tick_1s = t;
        if (done && clean_armed && power_on) begin
            ref_usage   = 0;
            clean_armed = 0;
        end else if (t && power_on && extracting && !cleaning && ref_usage < (1 << UW) - 1) begin
            ref_usage++;
        end
        @(negedge clk);
        tick_1s = 1'b0;
        if (start_clean && sc_mode != 1) sc_t = 0;
        else if (sc_t >= 0)              sc_t++;
        case (sc_mode)
            0: begin
                cleaning = (sc_t >= 2 && sc_t <= 7);
                done     = (sc_t == 7);
                if (sc_t >= 8) sc_t = -1;
            end
            2: begin
                cleaning = (sc_t >= 2);
                done     = 1'b0;
            end
            default: begin
                cleaning = 1'b0;
                done     = 1'b0;
                sc_t     = -1;
            end
        endcase
    endtask

    // Hold the button for 'hold' clocks inside a 'window'-clock observation
    task automatic press(input int hold, input int window, input bit tick_on_clean);
        logic aerr0;
        aerr0        = ack_error;
        n_start      = 0;
        n_rej        = 0;
        first_start  = -1;
        first_rej    = -1;
        first_ackerr = -1;
        for (int i = 1; i <= window; i++) begin
            btn_clean = (i <= hold);
            step(tick_on_clean && cleaning);
            if (start_clean === 1'b1) begin
                n_start++;
                if (first_start < 0) first_start = i;
            end
            if (req_reject === 1'b1) begin
                n_rej++;
                if (first_rej < 0) first_rej = i;
            end
            if (ack_error === 1'b1 && aerr0 !== 1'b1 && first_ackerr < 0) first_ackerr = i;
            chk("press_usage", 32'(usage_sec), 32'(ref_usage));
            chk("press_reminder", 32'(clean_reminder), 32'(ref_usage >= REM));
        end
        btn_clean = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"},    32'(start_clean),    0);
        chk({tag, "_reminder"}, 32'(clean_reminder), 0);
        chk({tag, "_usage"},    32'(usage_sec),      0);
        chk({tag, "_reject"},   32'(req_reject),     0);
        chk({tag, "_ackerr"},   32'(ack_error),      0);
    endtask

    initial begin
        int g;
        rst = 1'b1; tick_1s = 1'b0; power_on = 1'b1; in_standby = 1'b1;
        extracting = 1'b0; btn_clean = 1'b0; cleaning = 1'b0; done = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        step(0);

        // Scenario 1: short glitch ignored, a real press gives one start_clean
        g = $urandom_range(1, DB - 1);
        press(g, 14, 0);
        chk("s1_glitch_start", 32'(n_start), 0);
        chk("s1_glitch_reject", 32'(n_rej), 0);
        clean_armed = 1;
        press(8, 16, 0);
        chk("s1_start_count", 32'(n_start), 1);
        chk("s1_start_latency", 32'(first_start), 32'(LAT));
        chk("s1_reject_count", 32'(n_rej), 0);

        // Scenario 2: twelve qualifying ticks with random gaps
        extracting = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            repeat ($urandom_range(0, 2)) step(0);
            step(1);
            chk("s2_usage", 32'(usage_sec), 32'(i));
            chk("s2_reminder", 32'(clean_reminder), 32'(i >= int'(REM)));
        end

        // Random input noise with the button idle
        for (int i = 0; i < 32; i++) begin
            power_on   = 1'($urandom_range(0, 1));
            extracting = 1'($urandom_range(0, 1));
            in_standby = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)));
            chk("rand_usage", 32'(usage_sec), 32'(ref_usage));
            chk("rand_reminder", 32'(clean_reminder), 32'(ref_usage >= REM));
        end
        power_on = 1'b1; in_standby = 1'b1; extracting = 1'b1;

        // Scenario 3: clean completes with ticks during cleaning and on the done edge
        clean_armed = 1;
        press(8, 16, 1);
        chk("s3_start_count", 32'(n_start), 1);
        chk("s3_usage_cleared", 32'(usage_sec), 0);
        chk("s3_reminder_cleared", 32'(clean_reminder), 0);

        // Scenario 4: refused presses at the minimum accepted hold length
        in_standby = 1'b0;
        press(DB, 12, 0);
        chk("s4a_reject_count", 32'(n_rej), 1);
        chk("s4a_reject_latency", 32'(first_rej), 32'(LAT));
        chk("s4a_start_count", 32'(n_start), 0);
        in_standby = 1'b1; power_on = 1'b0;
        press(DB, 12, 0);
        chk("s4b_reject_count", 32'(n_rej), 1);
        chk("s4b_start_count", 32'(n_start), 0);
        power_on = 1'b1;

        // Scenario 5: no acknowledge, then a normal clean still works
        sc_mode = 1;
        press(8, 16, 0);
        chk("s5_start_count", 32'(n_start), 1);
        chk("s5_ackerr_cycle", 32'(first_ackerr), 32'(LAT + ACKT + 1));
        chk("s5_ackerr", 32'(ack_error), 1);
        sc_mode = 0; clean_armed = 1;
        press(8, 16, 0);
        chk("s5_retry_start", 32'(n_start), 1);
        chk("s5_retry_latency", 32'(first_start), 32'(LAT));
        chk("s5_ackerr_sticky", 32'(ack_error), 1);

        // Scenario 6: power loss mid-clean keeps usage
        repeat (7) step(1);
        chk("s6_usage7", 32'(usage_sec), 7);
        sc_mode = 2; clean_armed = 1;
        press(8, 16, 0);
        chk("s6_start_count", 32'(n_start), 1);
        press(8, 16, 0);
        chk("s6_busy_press_start", 32'(n_start), 0);
        chk("s6_busy_press_reject", 32'(n_rej), 0);
        power_on = 1'b0; clean_armed = 0;
        step(0);
        power_on = 1'b1; sc_mode = 0; sc_t = 6;
        step(0);
        step(0);
        chk("s6_usage_kept", 32'(usage_sec), 7);
        chk("s6_reminder", 32'(clean_reminder), 0);

        // Asynchronous reset in the middle of a clean
        repeat (4) step(1);
        chk("s6_usage11", 32'(usage_sec), 11);
        chk("s6_reminder11", 32'(clean_reminder), 1);
        sc_mode = 2; clean_armed = 1;
        press(8, 12, 0);
        chk("s6_rst_start", 32'(n_start), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0; ref_usage = 0; clean_armed = 0;
        sc_mode = 0; sc_t = -1; cleaning = 1'b0; done = 1'b0;
        step(0);
        chk_all_zero("post_rst");
        step(1);
        chk("post_rst_tick", 32'(usage_sec), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
